fifo_rd_stream_adapter: RTL and testbench

// - Read-side stage placed directly after the dual-clock FIFO, in the FIFO's read clock domain.
// - Drives the FIFO's rd_en/dout/empty port (dout is registered, one cycle behind rd_en).
// - Presents the data as a valid/ready stream, first-word-fall-through, with a 2-entry skid buffer.
// - Sustains one word per cycle under continuous out_ready.

---
 rtl/fifo_rd_stream_adapter.sv | 159 +++++++++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
//
// Read-side stage that sits directly after a dual-clock FIFO, clocked by the
// FIFO read clock. It drives the FIFO's rd_en/dout/empty port and presents the
// words as a first-word-fall-through valid/ready stream. A 2-entry skid buffer
// absorbs the one-cycle registered-dout latency, so the stage sustains one word
// per cycle under continuous out_ready.
//
// Ports:
//   clk          FIFO read clock
//   rst_n        asynchronous active-low reset
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   FIFO read strobe (combinational)
//   flush        synchronous drop of buffered and in-flight words
//   out_valid    stream valid (registered)
//   out_data     stream data (registered), head of the skid buffer
//   out_ready    stream ready
//   occupancy    words held in the skid buffer, 0..2 (registered)
//
// Optional feature, macro FIFO_RD_STREAM_STATS_EN:
//   xfer_count   32-bit count of stream pops
//   stall_count  32-bit count of cycles with out_valid=1 and out_ready=0
//   Both clear on reset and on flush, and wrap at 2^32.
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]      xfer_count,
    output logic [31:0]      stall_count
`endif
);

    logic [1:0]       occ_q, occ_d;
    logic             pend_q, pend_d;
    logic             head_q, head_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] entry_q [2];
    logic [WIDTH-1:0] entry_d [2];

    logic             pop;
    logic             push;
    logic             tail;
    logic [2:0]       committed;

    assign pop  = out_valid_q & out_ready;
    // A word arriving during flush belongs to a read issued before the flush.
    assign push = pend_q & ~flush;

    // Words the buffer will hold once the in-flight read lands and this
    // cycle's pop retires. pop implies occ_q >= 1, so this never underflows.
    assign committed = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};

    // rst_n gating keeps the strobe low for the whole reset, not just after
    // the first edge.
    assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & (committed < 3'd2);

    // Tail slot: with one word held it is the other slot; with zero words it
    // is the head; with two words a capture only happens alongside a pop, and
    // then the slot being freed (the head) is the tail.
    assign tail = head_q ^ (occ_q == 2'd1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        entry_d = entry_q;
        occ_d   = occ_q;
        head_d  = head_q;
        pend_d  = fifo_rd_en;

        if (flush) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
        end else begin
            if (push) begin
                entry_d[tail] = fifo_dout;
            end
            head_d = head_q ^ pop;
            occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        end

        out_valid_d = (occ_d != 2'd0);
        out_data_d  = entry_d[head_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= 2'd0;
            pend_q      <= 1'b0;
            head_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            // NOTE: the two skid entries are cleared too; they are tiny and a
            // defined out_data after reset depends on them.
            entry_q     <= '{default: '0};
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop
            // samples the pre-edge values regardless of statement order.
            occ_q       <= occ_d;
            pend_q      <= pend_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            entry_q     <= entry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occupancy = occ_q;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] xfer_count_q, xfer_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        xfer_count_d  = xfer_count_q + {31'd0, pop};
        stall_count_d = stall_count_q + {31'd0, out_valid_q & ~out_ready};
        if (flush) begin
            xfer_count_d  = 32'd0;
            stall_count_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q  <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            xfer_count_q  <= xfer_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign xfer_count  = xfer_count_q;
    assign stall_count = stall_count_q;
`endif

    // The read-issue rule guarantees room for every captured word.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(pend_q && !flush && occ_q == 2'd2 && !pop)
    );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
//
// Self-checking bench. A queue-based FIFO stands in for the upstream FIFO and a
// queue-based model of the skid buffer predicts rd_en, valid, data and
// occupancy every cycle. Directed scenarios pin the model with literal
// expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;

    localparam int WIDTH = 8;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_dout  = '0;
    logic             fifo_rd_en;
    logic             flush      = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready  = 1'b0;
    logic [1:0]       occupancy;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]      xfer_count;
    logic [31:0]      stall_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .occupancy  (occupancy)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .xfer_count (xfer_count),
        .stall_count(stall_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Upstream FIFO contents, model skid buffer, and the observed stream.
    logic [WIDTH-1:0] src[$];
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] out_log[$];
    bit               m_pend;
    logic [31:0]      m_xfer;
    logic [31:0]      m_stall;
    bit               last_rd;

    bit               hist_rd[$];
    bit               hist_v[$];
    logic [WIDTH-1:0] hist_d[$];
    int               hist_occ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) src.push_back(WIDTH'(base + i));
        fifo_empty = (src.size() == 0);
    endtask

    // One clock cycle: inputs are already set; compare at the falling edge,
    // advance the model, then let the upstream FIFO respond after the edge.
    task automatic cycle();
        bit pop, exp_rd;
        @(negedge clk);
        pop    = (mq.size() != 0) && out_ready;
        exp_rd = !fifo_empty && !flush && (mq.size() + int'(m_pend) - int'(pop)) < 2;
        check("fifo_rd_en", fifo_rd_en, exp_rd);
        check("out_valid", out_valid, mq.size() != 0);
        check("occupancy", occupancy, 32'(mq.size()));
        if (mq.size() != 0) check("out_data", out_data, mq[0]);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("xfer_count", xfer_count, m_xfer);
        check("stall_count", stall_count, m_stall);
`endif
        hist_rd.push_back(fifo_rd_en);
        hist_v.push_back(out_valid);
        hist_d.push_back(out_data);
        hist_occ.push_back(int'(occupancy));
        if (out_valid && out_ready) out_log.push_back(out_data);
        last_rd = fifo_rd_en;

        if (flush) begin
            m_xfer  = 0;
            m_stall = 0;
        end else begin
            m_xfer  = m_xfer + 32'(pop);
            m_stall = m_stall + 32'((mq.size() != 0) && !out_ready);
        end
        if (pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (m_pend) mq.push_back(fifo_dout);
        m_pend = exp_rd;

        @(posedge clk);
        #1;
        if (last_rd && src.size() != 0) fifo_dout = src.pop_front();
        fifo_empty = (src.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        out_log.delete();
        hist_rd.delete();
        hist_v.delete();
        hist_d.delete();
        hist_occ.delete();
    endtask

    task automatic model_clear();
        src.delete();
        mq.delete();
        m_pend     = 0;
        m_xfer     = 0;
        m_stall    = 0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst occupancy", occupancy, 0);
        check("rst out_data", out_data, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("rst xfer_count", xfer_count, 0);
        check("rst stall_count", stall_count, 0);
`endif
        fifo_empty = 1'b0;
        #1;
        check("rst rd_en gated", fifo_rd_en, 0);
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_log(input string name, input int base, input int n);
        check({name, " count"}, out_log.size(), n);
        for (int i = 0; i < n && i < out_log.size(); i++)
            check({name, " word"}, out_log[i], WIDTH'(base + i));
    endtask

    initial begin
        int run_len, best_run, first_v;

        // Single word.
        do_reset();
        load(1, 8'hA5);
        out_ready = 1'b1;
        run(5);
        check("single rd_en c0", hist_rd[0], 1);
        check("single rd_en c1", hist_rd[1], 0);
        check("single valid c1", hist_v[1], 0);
        check("single valid c2", hist_v[2], 1);
        check("single data c2", hist_d[2], 8'hA5);
        check("single valid c3", hist_v[3], 0);
        check("single occ c3", hist_occ[3], 0);

        // Streaming 16 words.
        do_reset();
        load(16, 0);
        out_ready = 1'b1;
        run(22);
        best_run = 0; run_len = 0; first_v = -1;
        foreach (hist_v[i]) begin
            if (hist_v[i]) begin
                run_len++;
                if (first_v < 0) first_v = i;
            end else run_len = 0;
            if (run_len > best_run) best_run = run_len;
        end
        check("stream first valid", first_v, 2);
        check("stream run length", best_run, 16);
        check_log("stream", 0, 16);

        // Backpressure.
        do_reset();
        load(8, 0);
        out_ready = 1'b0;
        run(10);
        check("bp occupancy", occupancy, 2);
        check("bp rd_en", fifo_rd_en, 0);
        check("bp out_data", out_data, 0);
        check("bp out_valid", out_valid, 1);
        out_ready = 1'b1;
        run(12);
        check_log("bp", 0, 8);

        // Toggling ready over 32 words.
        do_reset();
        load(32, 0);
        for (int k = 0; k < 80; k++) begin
            out_ready = (k % 2 == 0);
            cycle();
        end
        check_log("toggle", 0, 32);
`ifdef FIFO_RD_STREAM_STATS_EN
        check("toggle xfer_count", xfer_count, 32);
        check("toggle stall_count", stall_count, m_stall);
`endif

        // Flush with a full buffer.
        do_reset();
        load(10, 0);
        out_ready = 1'b0;
        run(5);
        check("flushA occ before", occupancy, 2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        out_log.delete();
        check("flushA valid", out_valid, 0);
        check("flushA occ", occupancy, 0);
        out_ready = 1'b1;
        run(6);
        check("flushA first word", out_log.size() > 0 ? 32'(out_log[0]) : 32'hFFFF, 2);

        // Flush with one word held and one in flight.
        do_reset();
        load(10, 0);
        out_ready = 1'b1;
        run(2);
        check("flushB pend issued", hist_rd[1], 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        out_log.delete();
        check("flushB valid", out_valid, 0);
        check("flushB occ", occupancy, 0);
        run(6);
        check("flushB first word", out_log.size() > 0 ? 32'(out_log[0]) : 32'hFFFF, 2);

        // Async reset mid-stream, between clock edges.
        do_reset();
        load(20, 50);
        out_ready = 1'b1;
        run(6);
        #3;
        rst_n = 1'b0;
        #1;
        check("async valid", out_valid, 0);
        check("async rd_en", fifo_rd_en, 0);
        check("async occ", occupancy, 0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_logs();
        run(4);
        check("async no stale", out_log.size(), 0);
        load(3, 100);
        run(8);
        check_log("async after", 100, 3);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (src.size() < 4 && $urandom_range(0, 1) == 1) begin
                src.push_back(WIDTH'($urandom));
                fifo_empty = 1'b0;
            end
            cycle();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
